// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - client/UART handshake bundle for the UART transmit arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           Req;
    logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
    logic [NUM_REQ-1:0]           Grant;
    logic [NUM_REQ-1:0]           Ack;
    logic                         Start_Err;
    logic                         Arb_Busy;
    logic                         CTS;
    logic [DATA_BITS-1:0]         Tx_Data;
    logic                         Transmit_Start;
    logic                         Tx_Busy;

    // master: requesters plus UART core; slave: the arbiter
    modport master (
        output Req, Req_Data, CTS, Tx_Busy,
        input  Grant, Ack, Start_Err, Arb_Busy, Tx_Data, Transmit_Start
    );

    modport slave (
        input  Req, Req_Data, CTS, Tx_Busy,
        output Grant, Ack, Start_Err, Arb_Busy, Tx_Data, Transmit_Start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among requesters
// Grants one requester, latches its byte, runs the Transmit_Start/Tx_Busy handshake, then acks.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   winner;
    logic               winner_vld;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (NUM_REQ == 1)
            return '0;
        return (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Scan ptr, ptr+1, ... so the requester just served sits last in line.
    always_comb begin
        logic [PTR_W-1:0] idx;
        winner     = '0;
        winner_vld = 1'b0;
        idx        = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!winner_vld && bus.Req[idx]) begin
                winner     = idx;
                winner_vld = 1'b1;
            end
            idx = wrap_inc(idx);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state              <= IDLE;
            ptr                <= '0;
            owner              <= '0;
            cnt                <= '0;
            bus.Grant          <= '0;
            bus.Ack            <= '0;
            bus.Start_Err      <= 1'b0;
            bus.Arb_Busy       <= 1'b0;
            bus.Tx_Data        <= '0;
            bus.Transmit_Start <= 1'b0;
        end else begin
            bus.Ack       <= '0;
            bus.Start_Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (winner_vld && bus.CTS && !bus.Tx_Busy) begin
                        owner              <= winner;
                        bus.Grant          <= NUM_REQ'(1) << winner;
                        bus.Tx_Data        <= bus.Req_Data[int'(winner)*DATA_BITS +: DATA_BITS];
                        bus.Transmit_Start <= 1'b1;
                        bus.Arb_Busy       <= 1'b1;
                        cnt                <= '0;
                        state              <= START;
                    end
                end
                START: begin
                    if (bus.Tx_Busy) begin
                        bus.Transmit_Start <= 1'b0;
                        state              <= BUSY;
                    end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        // UART never answered: release the slot without an Ack
                        bus.Transmit_Start <= 1'b0;
                        bus.Grant          <= '0;
                        bus.Start_Err      <= 1'b1;
                        bus.Arb_Busy       <= 1'b0;
                        ptr                <= wrap_inc(owner);
                        state              <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (!bus.Tx_Busy)
                        state <= DONE;
                end
                DONE: begin
                    bus.Ack      <= bus.Grant;
                    bus.Grant    <= '0;
                    bus.Arb_Busy <= 1'b0;
                    ptr          <= wrap_inc(owner);
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 16;

    logic Clk = 1'b0;
    logic Rst;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_BITS(DB)) ifc ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .START_TIMEOUT(TO)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc.slave)
    );

    always #5 Clk = ~Clk;

    int n_tests, n_fail, cyc;

    // transaction-level reference: rotation pointer, current owner, idle flag
    int             m_ptr, m_owner, err_cnt;
    bit             m_idle;
    logic [DB-1:0]  m_data;
    int             grant_log[$];
    int             ack_log[$];

    // UART core stand-in
    bit uart_on;
    int busy_delay, busy_len, u_state, u_cnt;

    logic [N-1:0]    req_s, g_s, a_s;
    logic [N*DB-1:0] data_s;
    logic            cts_s, busy_s, rst_s;

    task automatic monitor();
        int w;
        bit should;
        if (rst_s) begin
            m_ptr = 0; m_idle = 1; m_owner = -1;
            n_tests++;
            if ({ifc.Grant, ifc.Ack, ifc.Start_Err, ifc.Arb_Busy, ifc.Tx_Data, ifc.Transmit_Start} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: grant=%b ack=%b err=%b busy=%b data=%h ts=%b, expected all 0",
                         ifc.Grant, ifc.Ack, ifc.Start_Err, ifc.Arb_Busy, ifc.Tx_Data, ifc.Transmit_Start);
            end
            return;
        end
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && req_s[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        should = m_idle && cts_s && !busy_s && (req_s != 0);
        if (g_s == 0 && ifc.Grant != 0) begin
            n_tests++;
            if (!should || w < 0) begin
                n_fail++;
                $display("FAIL grant_legal: grant=%b appeared with idle=%0d cts=%b busy=%b req=%b",
                         ifc.Grant, m_idle, cts_s, busy_s, req_s);
                for (int i = 0; i < N; i++) if (ifc.Grant[i]) w = i;
            end else if (ifc.Grant !== N'(1) << w || ifc.Tx_Data !== data_s[w*DB +: DB]
                         || ifc.Transmit_Start !== 1'b1) begin
                n_fail++;
                $display("FAIL grant_pick: grant=%b data=%h ts=%b, expected grant=%b data=%h ts=1",
                         ifc.Grant, ifc.Tx_Data, ifc.Transmit_Start, N'(1) << w, data_s[w*DB +: DB]);
            end
            m_owner = w; m_idle = 0;
            m_data  = data_s[w*DB +: DB];
            grant_log.push_back(w);
        end else if (should) begin
            n_tests++; n_fail++;
            $display("FAIL grant_missing: grant=%b, expected requester %0d granted (req=%b)", ifc.Grant, w, req_s);
        end
        if (g_s != 0 && ifc.Grant != 0) begin
            n_tests++;
            if (ifc.Grant !== g_s || ifc.Tx_Data !== m_data) begin
                n_fail++;
                $display("FAIL grant_hold: grant=%b data=%h, expected grant=%b data=%h", ifc.Grant, ifc.Tx_Data, g_s, m_data);
            end
        end
        n_tests++;
        if ($countones(ifc.Grant) > 1) begin
            n_fail++;
            $display("FAIL multi_hot: grant=%b, expected at most one bit", ifc.Grant);
        end
        if (ifc.Ack != 0) begin
            n_tests++;
            if (m_idle || m_owner < 0 || ifc.Ack !== N'(1) << m_owner || a_s != 0) begin
                n_fail++;
                $display("FAIL ack: ack=%b prev_ack=%b, expected single pulse for owner %0d", ifc.Ack, a_s, m_owner);
            end
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            ack_log.push_back(m_owner);
            m_owner = -1; m_idle = 1;
        end
        if (ifc.Start_Err) begin
            n_tests++;
            if (m_idle || m_owner < 0 || ifc.Ack != 0) begin
                n_fail++;
                $display("FAIL start_err: err=1 ack=%b, expected only while a frame is starting", ifc.Ack);
            end
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            err_cnt++;
            m_idle = 1;
        end
    endtask

    task automatic uart_model();
        if (rst_s) begin
            u_state = 0; ifc.Tx_Busy = 1'b0;
            return;
        end
        case (u_state)
            0: if (uart_on && ifc.Transmit_Start) begin u_cnt = busy_delay; u_state = 1; end
            1: begin
                u_cnt--;
                if (u_cnt == 0) begin ifc.Tx_Busy = 1'b1; u_cnt = busy_len; u_state = 2; end
            end
            default: begin
                u_cnt--;
                if (u_cnt == 0) begin ifc.Tx_Busy = 1'b0; u_state = 0; end
            end
        endcase
    endtask

    task automatic step();
        req_s = ifc.Req; data_s = ifc.Req_Data; cts_s = ifc.CTS;
        busy_s = ifc.Tx_Busy; rst_s = Rst; g_s = ifc.Grant; a_s = ifc.Ack;
        @(posedge Clk);
        #1;
        cyc++;
        monitor();
        uart_model();
    endtask

    task automatic do_reset();
        Rst = 1'b1; ifc.Req = '0; ifc.CTS = 1'b1;
        uart_on = 1; busy_delay = 2; busy_len = 4;
        step(); step();
        Rst = 1'b0;
        grant_log.delete(); ack_log.delete(); err_cnt = 0;
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] ack_v);
        ack_v = '0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ifc.Ack != 0) begin ack_v = ifc.Ack; break; end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; ifc.Req = 4'b1111; ifc.Req_Data = 32'hDEADBEEF;
        step(); step();
        Rst = 1'b0; ifc.Req = '0;
        step();
        n_tests++;
        if (ifc.Grant !== '0 || ifc.Arb_Busy !== 1'b0 || ifc.Transmit_Start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: grant=%b busy=%b ts=%b, expected 0", ifc.Grant, ifc.Arb_Busy, ifc.Transmit_Start);
        end
    endtask

    task automatic test_single();
        int t0, t_rise, t_fall, t_ts, t_ack;
        logic [N-1:0] ack_v;
        do_reset();
        busy_delay = 2; busy_len = 12;
        ifc.Req_Data = $urandom;
        ifc.Req_Data[1*DB +: DB] = 8'hA5;
        ifc.Req = 4'b0010;
        step();
        t0 = cyc;
        n_tests++;
        if (ifc.Grant !== 4'b0010 || ifc.Tx_Data !== 8'hA5 || ifc.Transmit_Start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b data=%h ts=%b, expected 0010 a5 1", ifc.Grant, ifc.Tx_Data, ifc.Transmit_Start);
        end
        t_rise = -1; t_fall = -1; t_ts = -1; t_ack = -1; ack_v = '0;
        for (int i = 0; i < 40; i++) begin
            ifc.Req_Data = $urandom;
            step();
            if (ifc.Tx_Busy && t_rise < 0) t_rise = cyc;
            if (!ifc.Tx_Busy && t_rise >= 0 && t_fall < 0) t_fall = cyc;
            if (!ifc.Transmit_Start && t_ts < 0) t_ts = cyc;
            if (ifc.Ack != 0) begin t_ack = cyc; ack_v = ifc.Ack; break; end
        end
        ifc.Req = '0;
        n_tests++;
        if (t_rise != t0 + 2 || t_ts != t_rise + 1) begin
            n_fail++;
            $display("FAIL single_start_drop: ts fell at +%0d, expected +3", t_ts - t0);
        end
        n_tests++;
        if (t_ack != t_fall + 2 || t_fall != t_rise + 12 || ack_v !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b at +%0d, expected 0010 at +16", ack_v, t_ack - t0);
        end
        step();
        n_tests++;
        if (ifc.Ack !== '0) begin
            n_fail++;
            $display("FAIL single_ack_width: ack=%b one cycle later, expected 0000", ifc.Ack);
        end
    endtask

    task automatic run_until_acks(input int want, input int budget);
        for (int i = 0; i < budget && ack_log.size() < want; i++) begin
            ifc.Req_Data = $urandom;
            if (u_state == 0) begin busy_delay = $urandom_range(1, 4); busy_len = $urandom_range(1, 8); end
            step();
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        ifc.Req = 4'b1111;
        run_until_acks(5, 400);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= ack_log.size() || ack_log[i] != exp_order[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, (i < ack_log.size()) ? ack_log[i] : -1, exp_order[i]);
            end
        end
        ifc.Req = '0;
    endtask

    task automatic test_alternate();
        int exp_order[4];
        exp_order = '{0, 2, 0, 2};
        do_reset();
        ifc.Req = 4'b0101;
        run_until_acks(4, 400);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
                n_fail++;
                $display("FAIL alt_order[%0d]: got %0d, expected %0d", i, (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            end
        end
        ifc.Req = '0;
    endtask

    task automatic test_cts();
        logic [N-1:0] ack_v;
        int bad;
        do_reset();
        busy_delay = 2; busy_len = 6;
        ifc.CTS = 1'b0; ifc.Req = 4'b0001;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ifc.Grant != 0 || ifc.Transmit_Start) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL cts_block: %0d cycles with grant/start while CTS low, expected 0", bad);
        end
        ifc.CTS = 1'b1;
        step();
        n_tests++;
        if (ifc.Grant !== 4'b0001 || ifc.Transmit_Start !== 1'b1) begin
            n_fail++;
            $display("FAIL cts_release: grant=%b ts=%b, expected 0001 1", ifc.Grant, ifc.Transmit_Start);
        end
        for (int i = 0; i < 20 && ifc.Transmit_Start; i++) step();
        ifc.CTS = 1'b0;
        wait_ack(40, ack_v);
        ifc.Req = '0; ifc.CTS = 1'b1;
        n_tests++;
        if (ack_v !== 4'b0001) begin
            n_fail++;
            $display("FAIL cts_drop_busy: ack=%b, expected 0001", ack_v);
        end
    endtask

    task automatic test_timeout();
        int ts_cycles;
        logic [N-1:0] ack_v;
        do_reset();
        uart_on = 0;
        ifc.Req = 4'b1000;
        step();
        ts_cycles = ifc.Transmit_Start ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ifc.Transmit_Start) ts_cycles++;
            else break;
        end
        n_tests++;
        if (ts_cycles != TO || ifc.Start_Err !== 1'b1 || ifc.Ack !== '0 || ifc.Grant !== '0) begin
            n_fail++;
            $display("FAIL timeout: start high %0d cycles err=%b ack=%b grant=%b, expected %0d 1 0000 0000",
                     ts_cycles, ifc.Start_Err, ifc.Ack, ifc.Grant, TO);
        end
        uart_on = 1; busy_delay = 2; busy_len = 4;
        ifc.Req = 4'b1001;
        step();
        n_tests++;
        if (ifc.Start_Err !== 1'b0 || ifc.Grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL timeout_next: err=%b grant=%b, expected 0 0001", ifc.Start_Err, ifc.Grant);
        end
        wait_ack(40, ack_v);
        ifc.Req = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ack_v;
        do_reset();
        busy_delay = 1; busy_len = 30;
        ifc.Req = 4'b0100;
        step();
        for (int i = 0; i < 20 && ifc.Transmit_Start; i++) step();
        Rst = 1'b1; ifc.Req = 4'b1000;
        step();
        n_tests++;
        if (ifc.Arb_Busy !== 1'b0 || ifc.Grant !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b grant=%b, expected 0 0000", ifc.Arb_Busy, ifc.Grant);
        end
        Rst = 1'b0;
        busy_delay = 2; busy_len = 3;
        step();
        n_tests++;
        if (ifc.Grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: grant=%b, expected 1000", ifc.Grant);
        end
        wait_ack(40, ack_v);
        ifc.Req = '0;
        n_tests++;
        if (ack_v !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid_ack: ack=%b, expected 1000", ack_v);
        end
    endtask

    task automatic test_random();
        int diff;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < N; r++)
                if (!ifc.Req[r] && $urandom_range(0, 3) == 0) ifc.Req[r] = 1'b1;
            ifc.Req_Data = $urandom;
            ifc.CTS = ($urandom_range(0, 7) != 0);
            if (u_state == 0 && !ifc.Transmit_Start) begin
                uart_on    = ($urandom_range(0, 9) != 0);
                busy_delay = $urandom_range(1, 4);
                busy_len   = $urandom_range(1, 10);
            end
            step();
            ifc.Req = ifc.Req & ~ifc.Ack;
            if (ifc.Start_Err && grant_log.size() > 0) ifc.Req[grant_log[$]] = 1'b0;
        end
        diff = grant_log.size() - ack_log.size() - err_cnt;
        n_tests++;
        if (grant_log.size() < 20 || diff < 0 || diff > 1) begin
            n_fail++;
            $display("FAIL random_balance: grants=%0d acks=%0d errs=%0d", grant_log.size(), ack_log.size(), err_cnt);
        end
        ifc.Req = '0; ifc.CTS = 1'b1; uart_on = 1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        m_ptr = 0; m_owner = -1; m_idle = 1; m_data = '0; err_cnt = 0;
        u_state = 0; u_cnt = 0; uart_on = 1; busy_delay = 2; busy_len = 4;
        Rst = 1'b1;
        ifc.Req = '0; ifc.Req_Data = '0; ifc.CTS = 1'b1; ifc.Tx_Busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_alternate();
        test_cts();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
